// File: rtl/ex_stage_pkg.sv
// Shared defines for the execute stage: ALU select/op codes, reset-fill words,
// divider FSM state encoding and the EX/MEM latch record.
package ex_stage_pkg;

    localparam logic [2:0] ALUSEL_NOP   = 3'b000;
    localparam logic [2:0] ALUSEL_LOGIC = 3'b001;
    localparam logic [2:0] ALUSEL_SHIFT = 3'b010;
    localparam logic [2:0] ALUSEL_DIV   = 3'b011;

    localparam logic [7:0] ALUOP_AND  = 8'h24;
    localparam logic [7:0] ALUOP_OR   = 8'h25;
    localparam logic [7:0] ALUOP_XOR  = 8'h26;
    localparam logic [7:0] ALUOP_NOR  = 8'h27;
    localparam logic [7:0] ALUOP_SLL  = 8'h7C;
    localparam logic [7:0] ALUOP_SRL  = 8'h02;
    localparam logic [7:0] ALUOP_SRA  = 8'h03;
    localparam logic [7:0] ALUOP_DIV  = 8'h1A;
    localparam logic [7:0] ALUOP_DIVU = 8'h1B;

    localparam logic [31:0] ZERO_WORD    = '0;
    localparam logic [4:0]  NOP_REG_ADDR = '0;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'b00,
        DIV_BUSY = 2'b01,
        DIV_DONE = 2'b10
    } div_state_t;

    typedef struct packed {
        logic [4:0]  wd;
        logic        wreg;
        logic [31:0] wdata;
        logic        whilo;
        logic [31:0] hi;
        logic [31:0] lo;
    } exmem_t;

endpackage

// File: rtl/ex_stage_div.sv
// ex_div: 32-cycle restoring divider with IDLE/BUSY/DONE control.
// Operands are reduced to magnitudes on start; signs are reapplied in DONE.
// result = {remainder, quotient}. Divide by zero yields zero in one cycle.
import ex_stage_pkg::*;

module ex_div (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        signed_div,
    input  logic [31:0] opdata1,
    input  logic [31:0] opdata2,
    input  logic        annul,
    input  logic        stall,
    output logic [63:0] result,
    output logic        ready,
    output logic        stallreq
);

    div_state_t  state_q, state_d;
    logic [4:0]  cnt_q;
    logic [31:0] rem_q, quo_q, dvs_q;
    logic        qneg_q, rneg_q;

    logic [31:0] abs1, abs2;
    logic [32:0] shifted, diff;
    logic        take;

    // Operand magnitudes and the trial subtraction for one restoring step.
    always_comb begin
        abs1    = (signed_div && opdata1[31]) ? -opdata1 : opdata1;
        abs2    = (signed_div && opdata2[31]) ? -opdata2 : opdata2;
        shifted = {rem_q, quo_q[31]};
        diff    = shifted - {1'b0, dvs_q};
        take    = ~diff[32];
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= DIV_IDLE;
        else     state_q <= state_d;
    end

    // Next state, stall request, ready flag and sign-corrected result.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            DIV_IDLE: if (start) state_d = (opdata2 == ZERO_WORD) ? DIV_DONE : DIV_BUSY;
            DIV_BUSY: if (cnt_q == 5'd31) state_d = DIV_DONE;
            DIV_DONE: if (!stall) state_d = DIV_IDLE;
            default:  state_d = DIV_IDLE;
        endcase
        if (annul) state_d = DIV_IDLE;

        stallreq = !rst && !annul &&
                   ((state_q == DIV_IDLE && start) || state_q == DIV_BUSY);
        ready    = (state_q == DIV_DONE);
        result   = {(rneg_q ? -rem_q : rem_q), (qneg_q ? -quo_q : quo_q)};
    end

    // Divider datapath: latch magnitudes/signs on start, then shift-subtract.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            rem_q  <= '0;
            quo_q  <= '0;
            dvs_q  <= '0;
            qneg_q <= 1'b0;
            rneg_q <= 1'b0;
        end else if (state_q == DIV_IDLE && start && !annul) begin
            cnt_q <= '0;
            rem_q <= '0;
            if (opdata2 == ZERO_WORD) begin
                quo_q  <= '0;
                dvs_q  <= '0;
                qneg_q <= 1'b0;
                rneg_q <= 1'b0;
            end else begin
                quo_q  <= abs1;
                dvs_q  <= abs2;
                qneg_q <= signed_div && (opdata1[31] ^ opdata2[31]);
                rneg_q <= signed_div && opdata1[31];
            end
        end else if (state_q == DIV_BUSY && !annul) begin
            // quo_q doubles as the dividend shift register: its MSB feeds the
            // partial remainder while quotient bits enter at the bottom.
            rem_q <= take ? diff[31:0] : shifted[31:0];
            quo_q <= {quo_q[30:0], take};
            cnt_q <= cnt_q + 5'd1;
        end
    end

endmodule

// File: rtl/ex_stage.sv
// ex_stage: execute stage with logic/shift ALU, optional divider and the
// EX/MEM pipeline register. Define EX_DIV_EN to build the divider; without it
// DIV selections behave as NOP and stallreq_o is tied low.
import ex_stage_pkg::*;

module ex_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  id_aluop_i,
    input  logic [2:0]  id_alusel_i,
    input  logic [31:0] id_reg1_i,
    input  logic [31:0] id_reg2_i,
    input  logic [4:0]  id_wd_i,
    input  logic        id_wreg_i,
    input  logic        stall_i,
    input  logic        flush_i,
    output logic [4:0]  mem_wd_o,
    output logic        mem_wreg_o,
    output logic [31:0] mem_wdata_o,
    output logic        mem_whilo_o,
    output logic [31:0] mem_hi_o,
    output logic [31:0] mem_lo_o,
    output logic        fwd_wreg_o,
    output logic [4:0]  fwd_wd_o,
    output logic [31:0] fwd_wdata_o,
    output logic        stallreq_o
);

    logic [31:0] logic_res, shift_res;
    logic        div_start;
    logic        div_ready;
    logic [63:0] div_result;
    exmem_t      nxt, exmem_q;

    assign div_start = (id_alusel_i == ALUSEL_DIV) &&
                       (id_aluop_i == ALUOP_DIV || id_aluop_i == ALUOP_DIVU);

`ifdef EX_DIV_EN
    ex_div u_div (
        .clk        (clk),
        .rst        (rst),
        .start      (div_start),
        .signed_div (id_aluop_i == ALUOP_DIV),
        .opdata1    (id_reg1_i),
        .opdata2    (id_reg2_i),
        .annul      (flush_i),
        .stall      (stall_i),
        .result     (div_result),
        .ready      (div_ready),
        .stallreq   (stallreq_o)
    );
`else
    assign div_ready  = 1'b0;
    assign div_result = '0;
    assign stallreq_o = 1'b0;
`endif

    // Bitwise logic unit.
    always_comb begin
        unique case (id_aluop_i)
            ALUOP_OR:  logic_res = id_reg1_i | id_reg2_i;
            ALUOP_AND: logic_res = id_reg1_i & id_reg2_i;
            ALUOP_XOR: logic_res = id_reg1_i ^ id_reg2_i;
            ALUOP_NOR: logic_res = ~(id_reg1_i | id_reg2_i);
            default:   logic_res = ZERO_WORD;
        endcase
    end

    // Shifter: value in reg2, amount from the low five bits of reg1.
    always_comb begin
        unique case (id_aluop_i)
            ALUOP_SLL: shift_res = id_reg2_i << id_reg1_i[4:0];
            ALUOP_SRL: shift_res = id_reg2_i >> id_reg1_i[4:0];
            ALUOP_SRA: shift_res = $signed(id_reg2_i) >>> id_reg1_i[4:0];
            default:   shift_res = ZERO_WORD;
        endcase
    end

    // Value the EX/MEM register would load this edge; a bubble while stalling.
    always_comb begin
        nxt    = '0;
        nxt.wd = id_wd_i;
        unique case (id_alusel_i)
            ALUSEL_LOGIC: begin
                nxt.wreg  = id_wreg_i;
                nxt.wdata = logic_res;
            end
            ALUSEL_SHIFT: begin
                nxt.wreg  = id_wreg_i;
                nxt.wdata = shift_res;
            end
            ALUSEL_DIV: begin
                nxt.whilo = div_start && div_ready;
                nxt.hi    = div_result[63:32];
                nxt.lo    = div_result[31:0];
            end
            default: nxt.wreg = 1'b0;
        endcase
        if (stallreq_o) nxt = '0;
    end

    assign fwd_wreg_o  = nxt.wreg;
    assign fwd_wd_o    = nxt.wd;
    assign fwd_wdata_o = nxt.wdata;

    // EX/MEM register: reset, then flush, then stall hold.
    always_ff @(posedge clk) begin
        if (rst)           exmem_q <= '0;
        else if (flush_i)  exmem_q <= '0;
        else if (!stall_i) exmem_q <= nxt;
    end

    assign mem_wd_o    = exmem_q.wd;
    assign mem_wreg_o  = exmem_q.wreg;
    assign mem_wdata_o = exmem_q.wdata;
    assign mem_whilo_o = exmem_q.whilo;
    assign mem_hi_o    = exmem_q.hi;
    assign mem_lo_o    = exmem_q.lo;

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage; divider scenarios run when EX_DIV_EN is defined.
module tb_ex_stage;

    typedef struct packed {
        logic [4:0]  wd;
        logic        wreg;
        logic [31:0] wdata;
        logic        whilo;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  id_aluop_i = '0;
    logic [2:0]  id_alusel_i = '0;
    logic [31:0] id_reg1_i = '0, id_reg2_i = '0;
    logic [4:0]  id_wd_i = '0;
    logic        id_wreg_i = 1'b0;
    logic        stall_i = 1'b0, flush_i = 1'b0;
    logic [4:0]  mem_wd_o;
    logic        mem_wreg_o;
    logic [31:0] mem_wdata_o;
    logic        mem_whilo_o;
    logic [31:0] mem_hi_o, mem_lo_o;
    logic        fwd_wreg_o;
    logic [4:0]  fwd_wd_o;
    logic [31:0] fwd_wdata_o;
    logic        stallreq_o;

    int checks = 0;
    int failures = 0;
    exp_t sb[$];

    ex_stage dut (
        .clk(clk), .rst(rst),
        .id_aluop_i(id_aluop_i), .id_alusel_i(id_alusel_i),
        .id_reg1_i(id_reg1_i), .id_reg2_i(id_reg2_i),
        .id_wd_i(id_wd_i), .id_wreg_i(id_wreg_i),
        .stall_i(stall_i), .flush_i(flush_i),
        .mem_wd_o(mem_wd_o), .mem_wreg_o(mem_wreg_o), .mem_wdata_o(mem_wdata_o),
        .mem_whilo_o(mem_whilo_o), .mem_hi_o(mem_hi_o), .mem_lo_o(mem_lo_o),
        .fwd_wreg_o(fwd_wreg_o), .fwd_wd_o(fwd_wd_o), .fwd_wdata_o(fwd_wdata_o),
        .stallreq_o(stallreq_o)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic drive(input logic [7:0] op, input logic [2:0] sel,
                         input logic [31:0] r1, input logic [31:0] r2,
                         input logic [4:0] wd, input logic wreg);
        id_aluop_i = op; id_alusel_i = sel; id_reg1_i = r1;
        id_reg2_i = r2; id_wd_i = wd; id_wreg_i = wreg;
    endtask

    function automatic exp_t mem_now();
        exp_t m;
        m.wd = mem_wd_o; m.wreg = mem_wreg_o; m.wdata = mem_wdata_o;
        m.whilo = mem_whilo_o; m.hi = mem_hi_o; m.lo = mem_lo_o;
        return m;
    endfunction

    function automatic exp_t model(input logic [7:0] op, input logic [2:0] sel,
                                   input logic [31:0] r1, input logic [31:0] r2,
                                   input logic [4:0] wd, input logic wreg);
        exp_t m;
        m = '0;
        m.wd = wd;
        if (sel == 3'b001) begin
            m.wreg = wreg;
            case (op)
                8'h25: m.wdata = r1 | r2;
                8'h24: m.wdata = r1 & r2;
                8'h26: m.wdata = r1 ^ r2;
                8'h27: m.wdata = ~(r1 | r2);
                default: m.wdata = 32'h0;
            endcase
        end else if (sel == 3'b010) begin
            m.wreg = wreg;
            case (op)
                8'h7C: m.wdata = r2 << r1[4:0];
                8'h02: m.wdata = r2 >> r1[4:0];
                8'h03: m.wdata = $signed(r2) >>> r1[4:0];
                default: m.wdata = 32'h0;
            endcase
        end
        return m;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        drive(8'h0, 3'b000, '0, '0, '0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        checks++; if (mem_now() !== exp_t'('0)) begin failures++; $display("FAIL reset_mem: got %h want 0", mem_now()); end
        checks++; if (stallreq_o !== 1'b0) begin failures++; $display("FAIL reset_stallreq: got %b want 0", stallreq_o); end
        rst = 1'b0;
    endtask

    task automatic test_logic();
        logic [7:0]  ops[5]  = '{8'h25, 8'h24, 8'h26, 8'h27, 8'h99};
        logic [31:0] r1s[5]  = '{32'h0000F0F0, 32'hFF00FF00, 32'hAAAA5555, 32'h0F0F0000, 32'hFFFFFFFF};
        logic [31:0] r2s[5]  = '{32'h00FF0000, 32'h0FF00FF0, 32'hFFFF0000, 32'h00000F0F, 32'hFFFFFFFF};
        logic [31:0] exps[5] = '{32'h00FFF0F0, 32'h0F000F00, 32'h5555_5555, 32'hF0F0F0F0, 32'h00000000};
        exp_t e, got;
        for (int unsigned i = 0; i < 5; i++) begin
            drive(ops[i], 3'b001, r1s[i], r2s[i], 5'(i + 1), 1'b1);
            e = '0; e.wd = 5'(i + 1); e.wreg = 1'b1; e.wdata = exps[i];
            sb.push_back(e);
            @(negedge clk);
            checks++;
            if ({fwd_wreg_o, fwd_wd_o, fwd_wdata_o} !== {e.wreg, e.wd, e.wdata}) begin
                failures++; $display("FAIL logic_fwd[%0d]: got %b/%0d/%h want %b/%0d/%h", i,
                                     fwd_wreg_o, fwd_wd_o, fwd_wdata_o, e.wreg, e.wd, e.wdata);
            end
            @(posedge clk); #1;
            got = sb.pop_front();
            checks++;
            if (mem_now() !== got) begin failures++; $display("FAIL logic_mem[%0d]: got %h want %h", i, mem_now(), got); end
        end
    endtask

    task automatic test_shift();
        logic [7:0]  ops[6]  = '{8'h03, 8'h7C, 8'h7C, 8'h02, 8'h03, 8'h55};
        logic [31:0] r1s[6]  = '{32'h4, 32'h24, 32'h4, 32'h21, 32'h2, 32'h1};
        logic [31:0] r2s[6]  = '{32'h80000000, 32'h80000000, 32'h1, 32'hF0000000, 32'h40000000, 32'h1234};
        logic [31:0] exps[6] = '{32'hF8000000, 32'h00000000, 32'h10, 32'h78000000, 32'h10000000, 32'h0};
        exp_t e, got;
        for (int unsigned i = 0; i < 6; i++) begin
            drive(ops[i], 3'b010, r1s[i], r2s[i], 5'(i + 10), 1'b1);
            e = '0; e.wd = 5'(i + 10); e.wreg = 1'b1; e.wdata = exps[i];
            sb.push_back(e);
            @(negedge clk);
            checks++;
            if (fwd_wdata_o !== e.wdata) begin
                failures++; $display("FAIL shift_fwd[%0d]: got %h want %h", i, fwd_wdata_o, e.wdata);
            end
            @(posedge clk); #1;
            got = sb.pop_front();
            checks++;
            if (mem_now() !== got) begin failures++; $display("FAIL shift_mem[%0d]: got %h want %h", i, mem_now(), got); end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] codes[8] = '{8'h25, 8'h24, 8'h26, 8'h27, 8'h7C, 8'h02, 8'h03, 8'h11};
        logic [7:0] op; logic [2:0] sel; logic [31:0] r1, r2; logic [4:0] wd; logic wreg;
        exp_t e, got;
        for (int unsigned i = 0; i < 24; i++) begin
            op = codes[$urandom_range(0, 7)];
            sel = 3'($urandom_range(0, 2));
            r1 = $urandom; r2 = $urandom; wd = 5'($urandom); wreg = 1'($urandom);
            drive(op, sel, r1, r2, wd, wreg);
            e = model(op, sel, r1, r2, wd, wreg);
            sb.push_back(e);
            @(negedge clk);
            checks++;
            if ({fwd_wreg_o, fwd_wd_o, fwd_wdata_o} !== {e.wreg, e.wd, e.wdata}) begin
                failures++; $display("FAIL b2b_fwd[%0d]: got %b/%0d/%h want %b/%0d/%h", i,
                                     fwd_wreg_o, fwd_wd_o, fwd_wdata_o, e.wreg, e.wd, e.wdata);
            end
            @(posedge clk); #1;
            got = sb.pop_front();
            checks++;
            if (mem_now() !== got) begin failures++; $display("FAIL b2b_mem[%0d]: got %h want %h", i, mem_now(), got); end
        end
    endtask

    task automatic test_stall();
        drive(8'h25, 3'b001, 32'h1100, 32'h0022, 5'd4, 1'b1);
        @(posedge clk); #1;
        checks++; if (mem_wdata_o !== 32'h1122) begin failures++; $display("FAIL stall_pre: got %h want 00001122", mem_wdata_o); end
        stall_i = 1'b1;
        drive(8'h24, 3'b001, 32'hFFFF0000, 32'h0F0F0F0F, 5'd5, 1'b1);
        for (int unsigned i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (fwd_wdata_o !== 32'h0F0F0000) begin failures++; $display("FAIL stall_fwd[%0d]: got %h want 0f0f0000", i, fwd_wdata_o); end
            @(posedge clk); #1;
            checks++; if ({mem_wd_o, mem_wdata_o} !== {5'd4, 32'h1122}) begin failures++; $display("FAIL stall_hold[%0d]: got %0d/%h want 4/00001122", i, mem_wd_o, mem_wdata_o); end
        end
        stall_i = 1'b0;
        @(posedge clk); #1;
        checks++; if ({mem_wd_o, mem_wdata_o} !== {5'd5, 32'h0F0F0000}) begin failures++; $display("FAIL stall_release: got %0d/%h want 5/0f0f0000", mem_wd_o, mem_wdata_o); end
    endtask

    task automatic test_flush();
        drive(8'h26, 3'b001, 32'h12345678, 32'h0, 5'd6, 1'b1);
        flush_i = 1'b1;
        @(posedge clk); #1;
        flush_i = 1'b0;
        checks++; if (mem_now() !== exp_t'('0)) begin failures++; $display("FAIL flush_bubble: got %h want 0", mem_now()); end
    endtask

`ifdef EX_DIV_EN
    task automatic test_div();
        logic [7:0]  ops[4] = '{8'h1A, 8'h1B, 8'h1A, 8'h1A};
        logic [31:0] as[4]  = '{32'hFFFFFFF9, 32'd100, 32'h80000000, 32'd5};
        logic [31:0] bs[4]  = '{32'd2, 32'd7, 32'hFFFFFFFF, 32'd0};
        logic [31:0] los[4] = '{32'hFFFFFFFD, 32'd14, 32'h80000000, 32'd0};
        logic [31:0] his[4] = '{32'hFFFFFFFF, 32'd2, 32'd0, 32'd0};
        int          ns[4]  = '{33, 33, 33, 1};
        exp_t e, got;
        int n;
        for (int unsigned i = 0; i < 4; i++) begin
            drive(ops[i], 3'b011, as[i], bs[i], 5'd7, 1'b1);
            e = '0; e.wd = 5'd7; e.whilo = 1'b1; e.hi = his[i]; e.lo = los[i];
            n = 0;
            while (1) begin
                @(negedge clk);
                if (!stallreq_o) break;
                n++;
                if (n == 2) begin
                    checks++; if (mem_now() !== exp_t'('0)) begin failures++; $display("FAIL div_bubble[%0d]: got %h want 0", i, mem_now()); end
                end
                if (n > 100) break;
            end
            checks++; if (n !== ns[i]) begin failures++; $display("FAIL div_stall_cycles[%0d]: got %0d want %0d", i, n, ns[i]); end
            checks++; if (fwd_wreg_o !== 1'b0) begin failures++; $display("FAIL div_fwd_wreg[%0d]: got %b want 0", i, fwd_wreg_o); end
            sb.push_back(e);
            @(posedge clk); #1;
            drive(8'h0, 3'b000, '0, '0, '0, 1'b0);
            got = sb.pop_front();
            checks++; if (mem_now() !== got) begin failures++; $display("FAIL div_result[%0d]: got %h want %h", i, mem_now(), got); end
        end
    endtask

    task automatic test_div_flush();
        exp_t e, got;
        int n = 0;
        drive(8'h1B, 3'b011, 32'd1000, 32'd3, 5'd8, 1'b1);
        while (n < 11) begin
            @(negedge clk);
            if (!stallreq_o) break;
            n++;
        end
        checks++; if (n !== 11) begin failures++; $display("FAIL divflush_busy: got %0d stall cycles want 11", n); end
        flush_i = 1'b1;
        @(posedge clk); #1;
        flush_i = 1'b0;
        checks++; if (mem_now() !== exp_t'('0)) begin failures++; $display("FAIL divflush_bubble: got %h want 0", mem_now()); end
        drive(8'h25, 3'b001, 32'h0000F0F0, 32'h00FF0000, 5'd9, 1'b1);
        e = '0; e.wd = 5'd9; e.wreg = 1'b1; e.wdata = 32'h00FFF0F0;
        sb.push_back(e);
        @(negedge clk);
        checks++; if (stallreq_o !== 1'b0) begin failures++; $display("FAIL divflush_stallreq: got %b want 0", stallreq_o); end
        checks++; if (fwd_wdata_o !== 32'h00FFF0F0) begin failures++; $display("FAIL divflush_fwd: got %h want 00fff0f0", fwd_wdata_o); end
        @(posedge clk); #1;
        got = sb.pop_front();
        checks++; if (mem_now() !== got) begin failures++; $display("FAIL divflush_or: got %h want %h", mem_now(), got); end
    endtask

    task automatic test_div_stall_done();
        exp_t e, got, snap;
        int n = 0;
        drive(8'h1B, 3'b011, 32'd100, 32'd7, 5'd11, 1'b1);
        while (1) begin
            @(negedge clk);
            if (!stallreq_o) break;
            n++;
            if (n > 100) break;
        end
        checks++; if (n !== 33) begin failures++; $display("FAIL divstall_cycles: got %0d want 33", n); end
        stall_i = 1'b1;
        snap = '0;
        for (int unsigned i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++; if (mem_now() !== snap) begin failures++; $display("FAIL divstall_hold[%0d]: got %h want %h", i, mem_now(), snap); end
            checks++; if (stallreq_o !== 1'b0) begin failures++; $display("FAIL divstall_req[%0d]: got %b want 0", i, stallreq_o); end
        end
        stall_i = 1'b0;
        e = '0; e.wd = 5'd11; e.whilo = 1'b1; e.hi = 32'd2; e.lo = 32'd14;
        sb.push_back(e);
        @(posedge clk); #1;
        drive(8'h0, 3'b000, '0, '0, '0, 1'b0);
        got = sb.pop_front();
        checks++; if (mem_now() !== got) begin failures++; $display("FAIL divstall_result: got %h want %h", mem_now(), got); end
    endtask

    task automatic test_rst_mid_div();
        drive(8'h1A, 3'b011, 32'd1000, 32'd3, 5'd12, 1'b1);
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        checks++; if (mem_now() !== exp_t'('0)) begin failures++; $display("FAIL rstdiv_mem: got %h want 0", mem_now()); end
        @(negedge clk);
        checks++; if (stallreq_o !== 1'b0) begin failures++; $display("FAIL rstdiv_stallreq: got %b want 0", stallreq_o); end
        rst = 1'b0;
        drive(8'h25, 3'b001, 32'h1, 32'h2, 5'd13, 1'b1);
        @(negedge clk);
        checks++; if ({stallreq_o, fwd_wreg_o, fwd_wdata_o} !== {1'b0, 1'b1, 32'h3}) begin
            failures++; $display("FAIL rstdiv_after: got %b/%b/%h want 0/1/00000003", stallreq_o, fwd_wreg_o, fwd_wdata_o);
        end
        @(posedge clk); #1;
    endtask
`else
    task automatic test_div_nop();
        exp_t e, got;
        drive(8'h1A, 3'b011, 32'hFFFFFFF9, 32'd2, 5'd7, 1'b1);
        e = '0; e.wd = 5'd7;
        sb.push_back(e);
        @(negedge clk);
        checks++; if (stallreq_o !== 1'b0) begin failures++; $display("FAIL divnop_stallreq: got %b want 0", stallreq_o); end
        checks++; if (fwd_wreg_o !== 1'b0) begin failures++; $display("FAIL divnop_fwd_wreg: got %b want 0", fwd_wreg_o); end
        @(posedge clk); #1;
        got = sb.pop_front();
        checks++; if (mem_now() !== got) begin failures++; $display("FAIL divnop_mem: got %h want %h", mem_now(), got); end
    endtask
`endif

    initial begin
        test_reset();
        test_logic();
        test_shift();
        test_back_to_back();
        test_stall();
        test_flush();
`ifdef EX_DIV_EN
        test_div();
        test_div_flush();
        test_div_stall_done();
        test_rst_mid_div();
`else
        test_div_nop();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ex_stage.md
EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 SHALL have port: clk  in  1  rising-edge clock.
REQ-002 SHALL have port: rst  in  1  reset; reset rst, synchronous, active-high.
REQ-003 SHALL have ports: id_aluop_i in 8, id_alusel_i in 3, id_reg1_i in 32, id_reg2_i in 32, id_wd_i in 5, id_wreg_i in 1; decoded operation, operands, destination and write enable from decode.
REQ-004 SHALL have ports: stall_i in 1 (hold EX/MEM register); flush_i in 1 (discard in-flight work).
REQ-005 SHALL have registered ports: mem_wd_o out 5, mem_wreg_o out 1, mem_wdata_o out 32, mem_whilo_o out 1, mem_hi_o out 32, mem_lo_o out 32; EX/MEM latch contents.
REQ-006 SHALL have combinational ports: fwd_wreg_o out 1, fwd_wd_o out 5, fwd_wdata_o out 32; current-cycle result for decode operand forwarding.
REQ-007 SHALL have port: stallreq_o out 1; request that upstream holds the current decode outputs.

Function
REQ-008 SHALL decode alusel: 000 NOP, 001 LOGIC, 010 SHIFT, 011 DIV; other alusel values treated as NOP.
REQ-009 LOGIC aluop: 0x25 OR, 0x24 AND, 0x26 XOR, 0x27 NOR, on reg1/reg2; unknown aluop -> 0.
REQ-010 SHIFT aluop: 0x7C SLL, 0x02 SRL, 0x03 SRA; value reg2, amount reg1[4:0] only; SRA sign-fills from reg2[31].
REQ-011 DIV aluop: 0x1A signed DIV, 0x1B unsigned DIVU; dividend reg1, divisor reg2; lo=quotient, hi=remainder, wreg forced 0, whilo 1.
REQ-012 fwd_* SHALL equal the value the EX/MEM register loads at the next edge absent stall/flush; fwd_wreg_o is 0 while stallreq_o is 1.
REQ-013 Divider FSM states: IDLE, BUSY, DONE.
REQ-014 IDLE + DIV op + divisor!=0 -> latch |operands| and signs, cnt=0, go BUSY; stallreq_o=1 combinationally in that cycle.
REQ-015 IDLE + DIV op + divisor==0 -> go DONE with quotient=remainder=0; stallreq_o=1 that one cycle.
REQ-016 BUSY: one restoring-division step per cycle, 32 cycles, stallreq_o=1; at cnt=31 go DONE.
REQ-017 DONE: apply signs (quotient negated if sign(a)^sign(b), remainder takes sign(a)), stallreq_o=0, EX/MEM loads result; go IDLE unless stall_i=1, in which case hold DONE.
REQ-018 Non-zero divide: stallreq_o high exactly 33 cycles, result in mem_* one edge after DONE cycle.
REQ-019 While stallreq_o=1 and stall_i=0, EX/MEM register SHALL load a bubble (wreg 0, whilo 0, wdata 0, wd 0).
REQ-020 stall_i=1: EX/MEM register holds all fields; divider advances in BUSY regardless.
REQ-021 flush_i=1: EX/MEM loads bubble, FSM -> IDLE, any division aborted; priority rst > flush_i > stall_i.
REQ-022 DIV op with 0x80000000 / 0xFFFFFFFF signed SHALL yield lo=0x80000000, hi=0 (wrap, no trap).

Reset
REQ-023 On rst all mem_* outputs 0, FSM IDLE, cnt 0, divider datapath registers 0.
REQ-024 rst mid-division aborts; stallreq_o 0 in the cycle following reset assertion.

Configuration
REQ-025 Macro EX_DIV_EN defined: divider and FSM as above.
REQ-026 EX_DIV_EN undefined: no FSM/divider logic; DIV alusel behaves as NOP (wreg 0, whilo 0), stallreq_o tied 0.

Structure
REQ-027 aluop/alusel codes, ZeroWord, NOPRegAddr, FSM state encoding SHALL live in the shared defines package.
REQ-028 Divider FSM and datapath SHALL be sub-module ex_div (start, signed, opdata1, opdata2, annul, result[63:0], ready); ex_stage instantiates it only under EX_DIV_EN.

Verification
REQ-029 OR 0x0000F0F0, 0x00FF0000 -> fwd_wdata_o 0x00FFF0F0 same cycle, mem_wdata_o next edge, wreg 1.
REQ-030 SRA reg1=4, reg2=0x80000000 -> 0xF8000000; SLL reg1=0x24 -> uses 4 -> 0x00000000 for reg2=0x80000000.
REQ-031 DIV -7 / 2 -> stallreq 33 cycles, lo 0xFFFFFFFD, hi 0xFFFFFFFF, whilo 1; DIVU 100/7 -> lo 14, hi 2.
REQ-032 DIV 5 / 0 -> stallreq 1 cycle, lo=hi=0, whilo 1.
REQ-033 Start DIV, flush_i at BUSY cycle 10 -> bubble, stallreq 0 next cycle, next OR executes normally.
REQ-034 stall_i high 3 cycles during DONE -> mem_* unchanged, result loads on first cycle stall_i=0; rst mid-BUSY -> all outputs 0.
